jk_excitation_driver: RTL and testbench
=======================================

JK_EXCITATION_DRIVER -- requirements
Module: jk_excitation_driver

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set the number of target-bit buffer entries (power of two, 2..16).
REQ-002 Parameter CNT_W, default 16, SHALL set the width of done_cnt.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 clear_n  input  1  SHALL be the asynchronous, active-low reset, shared with the driven external JK flip-flop.
REQ-005 in_valid  input  1  SHALL indicate that in_bit carries a desired next Q value.
REQ-006 in_bit  input  1  SHALL be the desired Q value of the external flip-flop.
REQ-007 in_ready  output  1  SHALL be high when the buffer can accept a bit.
REQ-008 J, K  output  1 each  SHALL be the registered excitation inputs to the external JK flip-flop.
REQ-009 q_fb  input  1  SHALL be the Q output fed back from the external flip-flop.
REQ-010 busy  output  1  SHALL be high while the FSM is not in IDLE or the buffer is non-empty.
REQ-011 err_pulse  output  1  SHALL be a registered one-cycle pulse on each feedback mismatch.
REQ-012 err_cnt  output  8  SHALL count mismatches, saturating at 255.
REQ-013 done_cnt  output  CNT_W  SHALL count checked bits, wrapping to 0.

Function
REQ-014 A bit SHALL be pushed when in_valid && in_ready; in_ready SHALL equal !full, so a push is never accepted while the buffer is full, even when a pop occurs in the same cycle.
REQ-015 The FSM SHALL have states IDLE, DRIVE and CHECK.
REQ-016 From IDLE, when the buffer is non-empty, the FSM SHALL pop one bit into target, register J/K from (q_exp, target) and enter DRIVE; a bit pushed into an empty buffer SHALL be popped on the following edge.
REQ-017 In DRIVE, J/K SHALL hold the excitation for exactly one cycle; on the exit edge J and K SHALL return to 0 and the FSM SHALL enter CHECK.
REQ-018 In CHECK, q_fb SHALL be compared with target; on mismatch, err_pulse SHALL go high in the next cycle and err_cnt SHALL increment unless already 255; done_cnt SHALL increment on every CHECK.
REQ-019 On leaving CHECK, q_exp SHALL load q_fb (resynchronise); the FSM SHALL go to DRIVE with a new pop if the buffer is non-empty, otherwise to IDLE; sustained throughput SHALL be one bit per 2 cycles.
REQ-020 The buffer SHALL be circular, with read and write pointers wrapping modulo FIFO_DEPTH and the full and empty states distinguished.
REQ-021 In IDLE and CHECK, J and K SHALL both be 0 (hold).

Reset
REQ-022 When clear_n is low, the block SHALL asynchronously force: FSM to IDLE; buffer to empty; J=0, K=0, q_exp=0, err_pulse=0, err_cnt=0, done_cnt=0, busy=0; in_ready=1.
REQ-023 Asserting reset mid-operation SHALL discard all buffered and in-flight bits with no count update; operation SHALL resume at the first rising edge after clear_n rises.

Configuration
REQ-024 With macro JK_TOGGLE_OPT_EN defined, excitation SHALL use toggle/hold: J=K=1 when target != q_exp, otherwise J=K=0.
REQ-025 Without JK_TOGGLE_OPT_EN, excitation SHALL use explicit set/reset: target=1 gives J=1, K=0; target=0 gives J=0, K=1, regardless of q_exp.

Verification
REQ-026 Reset, then push 1,0,0,1 against a correct JK model -> with the macro, J/K in DRIVE cycles = 11,11,00,11 (without the macro: 10,01,01,10); err_cnt=0; done_cnt=4; busy low afterwards.
REQ-027 Push 1,1,1 against a model stuck at Q=0 -> three err_pulse pulses; err_cnt=3; done_cnt=3.
REQ-028 Hold q_fb=0 and push 300 bits of value 1 -> err_cnt saturates at 255; done_cnt=300.
REQ-029 Drive in_valid=1 for 8 consecutive cycles from IDLE -> in_ready falls once FIFO_DEPTH bits are stored; no bit is lost or duplicated; all 8 bits are checked in order.
REQ-030 Pulse clear_n low during DRIVE with 3 bits buffered -> J=K=0, buffer empty and counters 0 immediately; the next pushed bit completes normally.

Source files
------------

// File: rtl/jk_excitation_driver.sv
// ---------------------------------------------------------------------------
// jk_excitation_driver
//
// Purpose:
//   Buffers a stream of desired Q values for an external JK flip-flop,
//   turns each one into a one-cycle J/K excitation, then checks the
//   flip-flop's fed-back Q against the desired value. Mismatches raise a
//   one-cycle err_pulse and bump a saturating error counter; every checked
//   bit bumps a wrapping done counter. One bit is serviced every 2 cycles
//   when the buffer is kept fed.
//
// Configuration macro:
//   JK_TOGGLE_OPT_EN  defined   -> toggle/hold excitation
//                                  (J=K=1 when target != q_exp, else J=K=0)
//                     undefined -> set/reset excitation
//                                  (target=1 -> J=1,K=0; target=0 -> J=0,K=1)
//
// Parameters:
//   FIFO_DEPTH  target-bit buffer entries (power of two, 2..16)
//   CNT_W       width of done_cnt
//
// Ports:
//   clk        in   single clock, rising edge
//   clear_n    in   asynchronous active-low reset (shared with external FF)
//   in_valid   in   in_bit carries a desired next Q value
//   in_bit     in   desired Q value
//   in_ready   out  buffer can accept a bit (= not full)
//   J, K       out  registered excitation to the external JK flip-flop
//   q_fb       in   Q fed back from the external flip-flop
//   busy       out  FSM not idle or buffer non-empty
//   err_pulse  out  registered one-cycle pulse per feedback mismatch
//   err_cnt    out  mismatch count, saturates at 255
//   done_cnt   out  checked-bit count, wraps to 0
// ---------------------------------------------------------------------------
module jk_excitation_driver #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             in_ready,
    output logic             J,
    output logic             K,
    input  logic             q_fb,
    output logic             busy,
    output logic             err_pulse,
    output logic [7:0]       err_cnt,
    output logic [CNT_W-1:0] done_cnt
);

    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DRIVE = 2'b01,
        ST_CHECK = 2'b10
    } state_t;

    state_t                state_r;
    state_t                state_nx_s;

    logic [FIFO_DEPTH-1:0] mem_r;
    logic [AW-1:0]         wr_ptr_r;
    logic [AW-1:0]         rd_ptr_r;
    logic [AW:0]           count_r;

    logic                  full_s;
    logic                  empty_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  head_s;

    logic                  target_r;
    logic                  q_exp_r;
    logic                  q_ref_s;
    logic [1:0]            exc_s;
    logic                  j_nx_s;
    logic                  k_nx_s;
    logic                  check_s;
    logic                  mismatch_s;

`ifdef JK_TOGGLE_OPT_EN
    // Toggle/hold: only excite when the flip-flop has to change state.
    function automatic logic [1:0] excite(input logic q_cur, input logic tgt);
        excite = (tgt != q_cur) ? 2'b11 : 2'b00;
    endfunction
`else
    // Set/reset: the excitation depends only on the target, never on Q.
    function automatic logic [1:0] excite(input logic unused_q, input logic tgt);
        excite = tgt ? 2'b10 : 2'b01;
    endfunction
`endif

    // Buffer status; full and empty are told apart by the occupancy count.
    assign full_s   = (count_r == DEPTH_C);
    assign empty_s  = (count_r == {(AW+1){1'b0}});
    assign head_s   = mem_r[rd_ptr_r];
    assign push_s   = in_valid & ~full_s;
    assign in_ready = ~full_s;
    assign busy     = (state_r != ST_IDLE) | ~empty_s;

    assign mismatch_s = q_fb ^ target_r;

    // Excitation reference: leaving CHECK the flip-flop state is resynchronised
    // from q_fb in the same edge, so the freshly observed value is used there.
    always_comb begin
        q_ref_s = q_exp_r;
        if (state_r == ST_CHECK) begin
            q_ref_s = q_fb;
        end else begin
            q_ref_s = q_exp_r;
        end
        exc_s = excite(q_ref_s, head_s);
    end

    // Next-state and per-edge actions of the IDLE/DRIVE/CHECK sequencer.
    always_comb begin
        state_nx_s = state_r;
        pop_s      = 1'b0;
        check_s    = 1'b0;
        j_nx_s     = 1'b0;
        k_nx_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    pop_s      = 1'b1;
                    j_nx_s     = exc_s[1];
                    k_nx_s     = exc_s[0];
                    state_nx_s = ST_DRIVE;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                state_nx_s = ST_CHECK;
            end
            ST_CHECK: begin
                check_s = 1'b1;
                if (!empty_s) begin
                    pop_s      = 1'b1;
                    j_nx_s     = exc_s[1];
                    k_nx_s     = exc_s[0];
                    state_nx_s = ST_DRIVE;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Circular target-bit buffer; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            mem_r    <= {FIFO_DEPTH{1'b0}};
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= in_bit;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Excitation outputs, target capture, feedback check and counters.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            J         <= 1'b0;
            K         <= 1'b0;
            target_r  <= 1'b0;
            q_exp_r   <= 1'b0;
            err_pulse <= 1'b0;
            err_cnt   <= 8'd0;
            done_cnt  <= {CNT_W{1'b0}};
        end else begin
            J         <= j_nx_s;
            K         <= k_nx_s;
            err_pulse <= check_s & mismatch_s;
            if (pop_s) begin
                target_r <= head_s;
            end
            if (check_s) begin
                q_exp_r  <= q_fb;
                done_cnt <= done_cnt + CNT_W'(1);
                if (mismatch_s && (err_cnt != 8'hFF)) begin
                    err_cnt <= err_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_jk_excitation_driver.sv
module tb_jk_excitation_driver;

    localparam int DEPTH      = 4;
    localparam int CNT_W      = 16;
    localparam int SLOT_FREE  = 0;
    localparam int SLOT_DRIVE = 1;
    localparam int SLOT_CHECK = 2;

`ifdef JK_TOGGLE_OPT_EN
    localparam logic [7:0] EXP26 = 8'b11_11_00_11;
`else
    localparam logic [7:0] EXP26 = 8'b10_01_01_10;
`endif

    logic             clk = 1'b0;
    logic             clear_n;
    logic             in_valid;
    logic             in_bit;
    logic             in_ready;
    logic             J;
    logic             K;
    logic             q_fb;
    logic             busy;
    logic             err_pulse;
    logic [7:0]       err_cnt;
    logic [CNT_W-1:0] done_cnt;

    // environment: external JK flip-flop plus fault injection
    logic q_ext;
    logic flip_r  = 1'b0;
    logic flip_en = 1'b0;
    logic stuck0  = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    // behavioural model state
    logic             m_q[$];
    int               m_slot;
    logic             m_tgt;
    logic             m_qexp;
    logic             m_j;
    logic             m_k;
    logic             m_err_pulse;
    int               m_err_cnt;
    logic [CNT_W-1:0] m_done;
    logic             m_acc;
    logic [1:0]       m_e;

    logic [1:0] cap_q[$];
    int         pulse_seen = 0;
    logic       saw_full   = 1'b0;

    jk_excitation_driver #(.FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .clear_n   (clear_n),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .in_ready  (in_ready),
        .J         (J),
        .K         (K),
        .q_fb      (q_fb),
        .busy      (busy),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt),
        .done_cnt  (done_cnt)
    );

    always #5 clk = ~clk;

    assign q_fb = stuck0 ? 1'b0 : (q_ext ^ flip_r);

    // external JK flip-flop, cleared together with the driver
    always @(posedge clk or negedge clear_n) begin
        if (!clear_n) q_ext <= 1'b0;
        else begin
            case ({J, K})
                2'b01:   q_ext <= 1'b0;
                2'b10:   q_ext <= 1'b1;
                2'b11:   q_ext <= ~q_ext;
                default: q_ext <= q_ext;
            endcase
        end
    end

    // occasional feedback corruption
    always @(negedge clk) begin
        flip_r <= flip_en ? ($urandom_range(0, 5) == 0) : 1'b0;
    end

`ifdef JK_TOGGLE_OPT_EN
    function automatic logic [1:0] model_exc(input logic q, input logic t);
        return (q != t) ? 2'b11 : 2'b00;
    endfunction
`else
    function automatic logic [1:0] model_exc(input logic unused_q, input logic t);
        return t ? 2'b10 : 2'b01;
    endfunction
`endif

    // model: a bit occupies a 2-cycle service slot (drive, then check)
    always @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            m_q.delete();
            m_slot      = SLOT_FREE;
            m_tgt       = 1'b0;
            m_qexp      = 1'b0;
            m_j         = 1'b0;
            m_k         = 1'b0;
            m_err_pulse = 1'b0;
            m_err_cnt   = 0;
            m_done      = '0;
        end else begin
            m_acc       = in_valid && (m_q.size() < DEPTH);
            m_err_pulse = 1'b0;
            if (m_slot == SLOT_CHECK) begin
                if (q_fb !== m_tgt) begin
                    m_err_pulse = 1'b1;
                    if (m_err_cnt < 255) m_err_cnt++;
                end
                m_done = m_done + CNT_W'(1);
                m_qexp = q_fb;
            end
            if (m_slot == SLOT_DRIVE) begin
                m_j    = 1'b0;
                m_k    = 1'b0;
                m_slot = SLOT_CHECK;
            end else if (m_q.size() > 0) begin
                m_tgt  = m_q.pop_front();
                m_e    = model_exc(m_qexp, m_tgt);
                m_j    = m_e[1];
                m_k    = m_e[0];
                m_slot = SLOT_DRIVE;
            end else begin
                m_j    = 1'b0;
                m_k    = 1'b0;
                m_slot = SLOT_FREE;
            end
            if (m_acc) m_q.push_back(in_bit);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // compare process: every cycle, DUT outputs against the model
    always @(negedge clk) begin
        check("J",         32'(J),         32'(m_j));
        check("K",         32'(K),         32'(m_k));
        check("in_ready",  32'(in_ready),  32'(m_q.size() < DEPTH));
        check("busy",      32'(busy),      32'((m_slot != SLOT_FREE) || (m_q.size() > 0)));
        check("err_pulse", 32'(err_pulse), 32'(m_err_pulse));
        check("err_cnt",   32'(err_cnt),   32'(m_err_cnt));
        check("done_cnt",  32'(done_cnt),  32'(m_done));
        if (m_slot == SLOT_DRIVE) cap_q.push_back({J, K});
        if (err_pulse) pulse_seen++;
        if (!in_ready) saw_full = 1'b1;
    end

    // offer one bit, keeping in_valid high until the model accepts it
    task automatic push_bit(input logic b);
        int   guard;
        logic acc;
        guard = 0;
        do begin
            acc      = (m_q.size() < DEPTH);
            in_valid = 1'b1;
            in_bit   = b;
            @(negedge clk);
            guard++;
        end while (!acc && guard < 1000);
        check("push_timeout", 32'(acc), 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(m_slot == SLOT_FREE && m_q.size() == 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(n < 2000), 32'd1);
        @(negedge clk);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        in_valid = 1'b0;
        #2 clear_n = 1'b0;
        @(negedge clk);
        cap_q.delete();
        pulse_seen = 0;
        saw_full   = 1'b0;
        #2 clear_n = 1'b1;
        @(negedge clk);
    endtask

    logic [7:0] exp26_v;
    logic [1:0] e2;
    logic       bits29[8];
    logic       qprev;
    logic       found;

    initial begin
        clear_n  = 1'b1;
        in_valid = 1'b0;
        in_bit   = 1'b0;
        #1 clear_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_J",        32'(J),         32'd0);
        check("rst_K",        32'(K),         32'd0);
        check("rst_in_ready", 32'(in_ready),  32'd1);
        check("rst_busy",     32'(busy),      32'd0);
        check("rst_err_cnt",  32'(err_cnt),   32'd0);
        check("rst_done_cnt", 32'(done_cnt),  32'd0);
        check("rst_err_pulse",32'(err_pulse), 32'd0);
        clear_n = 1'b1;
        @(negedge clk);

        // correct flip-flop, bits 1,0,0,1
        cap_q.delete();
        push_bit(1'b1); push_bit(1'b0); push_bit(1'b0); push_bit(1'b1);
        in_valid = 1'b0;
        wait_idle();
        exp26_v = EXP26;
        check("seq4_drive_count", 32'(cap_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < cap_q.size(); i++)
            check("seq4_jk", 32'(cap_q[i]), 32'(exp26_v[7-2*i -: 2]));
        check("seq4_err_cnt",  32'(err_cnt),  32'd0);
        check("seq4_done_cnt", 32'(done_cnt), 32'd4);
        check("seq4_busy",     32'(busy),     32'd0);

        // stuck-at-0 flip-flop, bits 1,1,1
        reset_dut();
        stuck0 = 1'b1;
        push_bit(1'b1); push_bit(1'b1); push_bit(1'b1);
        in_valid = 1'b0;
        wait_idle();
        check("stuck_pulses",   32'(pulse_seen), 32'd3);
        check("stuck_err_cnt",  32'(err_cnt),    32'd3);
        check("stuck_done_cnt", 32'(done_cnt),   32'd3);

        // 300 mismatches: error counter saturates
        reset_dut();
        for (int i = 0; i < 300; i++) push_bit(1'b1);
        in_valid = 1'b0;
        wait_idle();
        check("sat_err_cnt",  32'(err_cnt),  32'd255);
        check("sat_done_cnt", 32'(done_cnt), 32'd300);
        stuck0 = 1'b0;

        // 8 back-to-back offers fill the buffer; order preserved
        reset_dut();
        for (int i = 0; i < 8; i++) begin
            bits29[i] = 1'($urandom_range(0, 1));
            push_bit(bits29[i]);
        end
        in_valid = 1'b0;
        wait_idle();
        check("burst_saw_full", 32'(saw_full),     32'd1);
        check("burst_done_cnt", 32'(done_cnt),     32'd8);
        check("burst_err_cnt",  32'(err_cnt),      32'd0);
        check("burst_drives",   32'(cap_q.size()), 32'd8);
        qprev = 1'b0;
        for (int i = 0; i < 8 && i < cap_q.size(); i++) begin
`ifdef JK_TOGGLE_OPT_EN
            e2 = {bits29[i] ^ qprev, bits29[i] ^ qprev};
`else
            e2 = {bits29[i], ~bits29[i]};
`endif
            qprev = bits29[i];
            check("burst_jk_order", 32'(cap_q[i]), 32'(e2));
        end

        // reset in DRIVE with 3 bits buffered
        reset_dut();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            in_valid = 1'b1;
            in_bit   = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (m_slot == SLOT_DRIVE && m_q.size() == 3) found = 1'b1;
        end
        in_valid = 1'b0;
        check("midrst_reached", 32'(found), 32'd1);
        #2 clear_n = 1'b0;
        #1;
        check("midrst_J",        32'(J),         32'd0);
        check("midrst_K",        32'(K),         32'd0);
        check("midrst_in_ready", 32'(in_ready),  32'd1);
        check("midrst_busy",     32'(busy),      32'd0);
        check("midrst_err_cnt",  32'(err_cnt),   32'd0);
        check("midrst_done_cnt", 32'(done_cnt),  32'd0);
        @(negedge clk);
        #2 clear_n = 1'b1;
        @(negedge clk);
        push_bit(1'b1);
        in_valid = 1'b0;
        wait_idle();
        check("midrst_next_done", 32'(done_cnt), 32'd1);
        check("midrst_next_err",  32'(err_cnt),  32'd0);

        // randomized traffic with feedback corruption and one mid-run reset
        reset_dut();
        flip_en = 1'b1;
        for (int i = 0; i < 600; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_bit   = 1'($urandom_range(0, 1));
            if (i == 300) begin
                #3 clear_n = 1'b0;
                @(negedge clk);
                #3 clear_n = 1'b1;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        flip_en  = 1'b0;
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
